// File: rtl/fft_frame_stream.sv
// fft_frame_stream: packs a valid/ready sample stream into NPTS-point frames,
// launches them on a frame-parallel DFT/IDFT core and replays the result frame
// as a valid/ready stream, with per-frame mode, IFFT scaling and a watchdog.
module fft_frame_stream #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NPTS       = 8,
    parameter int unsigned IFFT_SHIFT = 1,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_re,
    input  logic [DATA_W-1:0]          in_im,
    input  logic                       in_inverse,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_re,
    output logic [DATA_W-1:0]          out_im,
    output logic                       out_last,
    output logic                       out_inverse,
    output logic                       core_next,
    output logic                       core_inverse,
    output logic [2*NPTS*DATA_W-1:0]   core_x,
    input  logic                       core_next_out,
    input  logic [2*NPTS*DATA_W-1:0]   core_y,
    output logic                       busy,
    output logic                       err_timeout
);
    localparam int unsigned IDX_W = $clog2(NPTS);
    localparam int unsigned LOG2N = $clog2(NPTS);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_NEXT, S_DATA, S_WAIT, S_CAP} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] in_re_w  [NPTS];
    logic [DATA_W-1:0] in_im_w  [NPTS];
    logic [DATA_W-1:0] out_re_w [NPTS];
    logic [DATA_W-1:0] out_im_w [NPTS];
    logic [IDX_W-1:0]  in_cnt, out_idx;
    logic              in_full, in_mode, out_full, out_mode;
    logic [WD_W-1:0]   wd;
    logic              in_acc_c, in_last_c, out_acc_c, abort_c;

    assign in_ready    = !in_full;
    assign in_acc_c    = in_valid && !in_full;
    assign in_last_c   = in_acc_c && (in_cnt == IDX_W'(NPTS - 1));
    assign out_acc_c   = out_full && out_ready;
    assign out_valid   = out_full;
    assign out_inverse = out_mode;
    assign out_re      = out_re_w[out_idx];
    assign out_im      = out_im_w[out_idx];
    assign out_last    = out_full && (out_idx == IDX_W'(NPTS - 1));

    // Inverse frames are divided by NPTS with an arithmetic (floor) shift.
    function automatic logic [DATA_W-1:0] scale_word(input logic [DATA_W-1:0] w, input logic inv);
        if ((IFFT_SHIFT != 0) && inv) begin
            return DATA_W'($signed(w) >>> LOG2N);
        end
        return w;
    endfunction

    // Present the input buffer to the core as one flat word vector.
    always_comb begin
        core_x = '0;
        for (int unsigned k = 0; k < NPTS; k++) begin
            core_x[(2*k)*DATA_W   +: DATA_W] = in_re_w[k];
            core_x[(2*k+1)*DATA_W +: DATA_W] = in_im_w[k];
        end
    end

    // Launch FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Launch FSM next state; a frame completing this cycle may launch next cycle.
    always_comb begin
        state_nxt = state;
        abort_c   = 1'b0;
        case (state)
            S_IDLE: if ((in_full || in_last_c) && !out_full) state_nxt = S_NEXT;
            S_NEXT: state_nxt = S_DATA;
            S_DATA: state_nxt = S_WAIT;
            S_WAIT: begin
                if (core_next_out) begin
                    state_nxt = S_CAP;
                end else if (wd >= WD_W'(TIMEOUT - 1)) begin
                    abort_c   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_CAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered core-side and status outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_next    <= 1'b0;
            core_inverse <= 1'b0;
            busy         <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            core_next   <= (state_nxt == S_NEXT);
            busy        <= (state_nxt != S_IDLE);
            err_timeout <= abort_c;
            if (state_nxt == S_NEXT) core_inverse <= in_mode;
        end
    end

    // Watchdog: wd equals the number of cycles since core_next was high.
    always_ff @(posedge clk) begin
        if (reset)                                  wd <= '0;
        else if (state == S_NEXT)                   wd <= WD_W'(1);
        else if (state == S_DATA || state == S_WAIT) wd <= wd + 1'b1;
    end

    // Input buffer fill; released once the core has seen it in DATA.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt  <= '0;
            in_full <= 1'b0;
            in_mode <= 1'b0;
            for (int unsigned k = 0; k < NPTS; k++) begin
                in_re_w[k] <= '0;
                in_im_w[k] <= '0;
            end
        end else begin
            if (in_acc_c) begin
                in_re_w[in_cnt] <= in_re;
                in_im_w[in_cnt] <= in_im;
                if (in_cnt == '0) in_mode <= in_inverse;
                if (in_last_c) begin
                    in_cnt  <= '0;
                    in_full <= 1'b1;
                end else begin
                    in_cnt <= in_cnt + 1'b1;
                end
            end
            if (state == S_DATA) in_full <= 1'b0;
        end
    end

    // Output buffer: captured in CAP, drained one sample per accepted beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_full <= 1'b0;
            out_mode <= 1'b0;
            out_idx  <= '0;
            for (int unsigned k = 0; k < NPTS; k++) begin
                out_re_w[k] <= '0;
                out_im_w[k] <= '0;
            end
        end else if (state == S_CAP) begin
            for (int unsigned k = 0; k < NPTS; k++) begin
                out_re_w[k] <= scale_word(core_y[(2*k)*DATA_W   +: DATA_W], core_inverse);
                out_im_w[k] <= scale_word(core_y[(2*k+1)*DATA_W +: DATA_W], core_inverse);
            end
            out_mode <= core_inverse;
            out_full <= 1'b1;
            out_idx  <= '0;
        end else if (out_acc_c) begin
            if (out_idx == IDX_W'(NPTS - 1)) begin
                out_full <= 1'b0;
                out_idx  <= '0;
            end else begin
                out_idx <= out_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_stream.sv
// Scoreboard bench for fft_frame_stream with an echoing core model.
`timescale 1ns/1ps
module tb_fft_frame_stream;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NPTS       = 8;
    localparam int unsigned IFFT_SHIFT = 1;
    localparam int unsigned TIMEOUT    = 64;
    localparam int unsigned CORE_LAT   = 20;
    localparam int unsigned BUS_W      = 2*NPTS*DATA_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0, in_inverse = 1'b0;
    logic [DATA_W-1:0] in_re = '0, in_im = '0;
    logic              out_ready = 1'b0;
    logic              in_ready, out_valid, out_last, out_inverse;
    logic [DATA_W-1:0] out_re, out_im;
    logic              core_next, core_inverse, busy, err_timeout;
    logic [BUS_W-1:0]  core_x;
    logic              core_next_out = 1'b0;
    logic [BUS_W-1:0]  core_y = '0;

    always #5 clk = ~clk;

    fft_frame_stream #(.DATA_W(DATA_W), .NPTS(NPTS), .IFFT_SHIFT(IFFT_SHIFT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im), .in_inverse(in_inverse),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_last(out_last), .out_inverse(out_inverse),
        .core_next(core_next), .core_inverse(core_inverse), .core_x(core_x),
        .core_next_out(core_next_out), .core_y(core_y),
        .busy(busy), .err_timeout(err_timeout)
    );

    typedef struct { logic [DATA_W-1:0] re; logic [DATA_W-1:0] im; logic last; logic inv; } exp_t;
    typedef struct { logic [BUS_W-1:0] x; logic inv; } launch_t;

    exp_t              exp_q[$];
    launch_t           launch_q[$];
    int                checks = 0, failures = 0, cyc = 0;
    int                n_core_next = 0, n_err = 0, last_next_cyc = 0, last_acc_cyc = 0;
    bit                chk_lat = 0, exp_timeout = 0, core_dead = 0;
    int                rdy_mode = 1;
    logic [DATA_W-1:0] fr_re[NPTS], fr_im[NPTS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: inverse frames divided by NPTS, rounded toward minus infinity.
    function automatic logic [DATA_W-1:0] ref_word(input logic [DATA_W-1:0] w, input logic inv);
        longint s, q;
        if (!(inv && (IFFT_SHIFT != 0))) return w;
        s = longint'($signed(w));
        q = s / longint'(NPTS);
        if (s < 0 && (s % longint'(NPTS)) != 0) q = q - 1;
        return DATA_W'(q);
    endfunction

    function automatic logic [BUS_W-1:0] pack_frame();
        logic [BUS_W-1:0] x;
        x = '0;
        for (int k = 0; k < NPTS; k++) begin
            x[(2*k)*DATA_W   +: DATA_W] = fr_re[k];
            x[(2*k+1)*DATA_W +: DATA_W] = fr_im[k];
        end
        return x;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: echo x as y, next_out CORE_LAT cycles after core_next.
    int lat_cnt = 0;
    bit pend = 0;
    always @(posedge clk) begin
        core_next_out <= 1'b0;
        if (core_next && !core_dead) begin
            core_y  <= core_x;
            pend    <= 1'b1;
            lat_cnt <= CORE_LAT - 2;
        end else if (pend) begin
            if (lat_cnt == 0) begin
                core_next_out <= 1'b1;
                pend          <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    // Downstream ready generator.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: scoreboard pops, hold rule, launch and watchdog checks.
    logic              prev_stall = 1'b0, h_last, h_inv;
    logic [DATA_W-1:0] h_re, h_im;
    always @(negedge clk) begin
        exp_t    e;
        launch_t l;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                check("hold_re", out_re, h_re);
                check("hold_im", out_im, h_im);
                check("hold_last", out_last, h_last);
                check("hold_inverse", out_inverse, h_inv);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_output: got re=0x%0h with no frame expected", out_re);
                end else begin
                    e = exp_q.pop_front();
                    check("out_re", out_re, e.re);
                    check("out_im", out_im, e.im);
                    check("out_last", out_last, e.last);
                    check("out_inverse", out_inverse, e.inv);
                end
            end
            prev_stall = out_valid && !out_ready;
            h_re = out_re; h_im = out_im; h_last = out_last; h_inv = out_inverse;
            if (core_next) begin
                n_core_next++;
                check("launch_out_empty", out_valid, 0);
                if (launch_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_launch: got core_next with no complete frame");
                end else begin
                    l = launch_q.pop_front();
                    check("core_x_frame", core_x == l.x, 1);
                    check("core_inverse", core_inverse, l.inv);
                end
                if (chk_lat) check("next_latency", cyc - last_acc_cyc, 1);
                last_next_cyc = cyc;
            end
            if (err_timeout) begin
                n_err++;
                check("timeout_expected", exp_timeout, 1);
                check("timeout_latency", cyc - last_next_cyc, TIMEOUT);
                check("timeout_busy", busy, 0);
                check("timeout_out_valid", out_valid, 0);
            end
        end
    end

    task automatic wait_ready();
        int g = 0;
        @(negedge clk);
        while (!in_ready && g < 3000) begin
            g++;
            @(negedge clk);
        end
        if (!in_ready) check("input_ready_timeout", in_ready, 1);
        last_acc_cyc = cyc;
    endtask

    task automatic send_frame(input logic inv, input bit expect_out, input int nsamp, input bit gaps);
        exp_t e;
        launch_t l;
        if (expect_out) begin
            for (int k = 0; k < NPTS; k++) begin
                e.re = ref_word(fr_re[k], inv);
                e.im = ref_word(fr_im[k], inv);
                e.last = (k == NPTS - 1);
                e.inv = inv;
                exp_q.push_back(e);
            end
        end
        for (int k = 0; k < nsamp; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            in_valid   = 1'b1;
            in_re      = fr_re[k];
            in_im      = fr_im[k];
            in_inverse = (k == 0) ? inv : 1'($urandom_range(0, 1));
            wait_ready();
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        if (nsamp == NPTS) begin
            l.x = pack_frame();
            l.inv = inv;
            launch_q.push_back(l);
        end
    endtask

    task automatic rand_frame();
        for (int k = 0; k < NPTS; k++) begin
            fr_re[k] = $urandom;
            fr_im[k] = $urandom;
        end
    endtask

    task automatic drain(input string name);
        int g = 0;
        while ((exp_q.size() != 0 || busy) && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        check({name, "_drain"}, 64'(exp_q.size()), 0);
    endtask

    initial begin
        int n0, e0, g;
        // 1. reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_core_next", core_next, 0);
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_err_timeout", err_timeout, 0);
        check("reset_core_x", core_x == '0, 1);
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // 2. forward ramp frame
        for (int k = 0; k < NPTS; k++) begin fr_re[k] = DATA_W'(k); fr_im[k] = '0; end
        chk_lat = 1;
        send_frame(1'b0, 1'b1, NPTS, 1'b0);
        drain("ramp");
        chk_lat = 0;

        // 3. inverse scaling, positive then negative words
        for (int k = 0; k < NPTS; k++) begin fr_re[k] = 32'h0000_0080; fr_im[k] = 32'h0000_0080; end
        send_frame(1'b1, 1'b1, NPTS, 1'b0);
        for (int k = 0; k < NPTS; k++) begin fr_re[k] = 32'hFFFF_FF80; fr_im[k] = 32'hFFFF_FF80; end
        send_frame(1'b1, 1'b1, NPTS, 1'b0);
        drain("scale");

        // 4. backpressure: two frames buffered, third blocked
        rdy_mode = 0;
        rand_frame(); send_frame(1'b0, 1'b1, NPTS, 1'b0);
        rand_frame(); send_frame(1'b1, 1'b1, NPTS, 1'b0);
        g = 0;
        while (!out_valid && g < 300) begin @(posedge clk); #1; g++; end
        n0 = n_core_next;
        rand_frame();
        in_valid = 1'b1; in_re = fr_re[0]; in_im = fr_im[0]; in_inverse = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        check("stall_in_ready", in_ready, 0);
        check("stall_no_launch", n_core_next, n0);
        check("stall_out_valid", out_valid, 1);
        rdy_mode = 2;
        send_frame(1'b0, 1'b1, NPTS, 1'b1);
        drain("stall");
        rdy_mode = 1;

        // 5. watchdog abort, then normal recovery
        core_dead = 1; exp_timeout = 1; e0 = n_err;
        rand_frame(); send_frame(1'b0, 1'b0, NPTS, 1'b0);
        g = 0;
        while (n_err == e0 && g < 300) begin @(posedge clk); #1; g++; end
        repeat (20) begin @(posedge clk); #1; end
        check("timeout_pulses", n_err - e0, 1);
        check("timeout_no_output", out_valid, 0);
        core_dead = 0; exp_timeout = 0;
        rand_frame(); send_frame(1'b1, 1'b1, NPTS, 1'b0);
        drain("recover");

        // 6. reset while waiting on the core with a partial next frame buffered
        rand_frame(); send_frame(1'b0, 1'b0, NPTS, 1'b0);
        rand_frame(); send_frame(1'b1, 1'b0, 4, 1'b0);
        while (cyc - last_next_cyc < 10) begin @(posedge clk); #1; end
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        n0 = n_core_next;
        repeat (25) begin @(posedge clk); #1; end
        check("post_reset_busy", busy, 0);
        check("post_reset_out_valid", out_valid, 0);
        check("post_reset_in_ready", in_ready, 1);
        check("post_reset_no_launch", n_core_next, n0);
        rand_frame(); send_frame(1'b0, 1'b1, NPTS, 1'b0);
        drain("fresh");

        // 7. random traffic
        rdy_mode = 2;
        for (int f = 0; f < 12; f++) begin
            rand_frame();
            send_frame(1'($urandom_range(0, 1)), 1'b1, NPTS, 1'b1);
        end
        drain("random");

        check("launch_queue_empty", 64'(launch_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
